// File: rtl/vga_pkg.sv
// Shared VGA definitions for the 640x480 pixel pipeline.
// Holds the visible-area geometry, the 2-bit colour constants, the packed
// {r,g,b} pixel type, the bounce-motion FSM encoding and small colour helpers.
// Both the timing generator and the renderer import this package.
package vga_pkg;

    localparam int H_VISIBLE = 640;
    localparam int V_VISIBLE = 480;

    localparam logic [1:0] C_BLACK = 2'b00;
    localparam logic [1:0] C_WHITE = 2'b11;
    localparam logic [1:0] C_BG_B  = 2'b01;

    typedef struct packed {
        logic [1:0] r;
        logic [1:0] g;
        logic [1:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_UPD_X = 2'd1,
        ST_UPD_Y = 2'd2
    } motion_state_t;

    // Each colour-index bit drives both bits of one channel.
    function automatic rgb_t palette(input logic [2:0] c);
        rgb_t p;
        p.r = {2{c[2]}};
        p.g = {2{c[1]}};
        p.b = {2{c[0]}};
        return p;
    endfunction

    // Colour index cycles 1..7; 0 would be black and is never used.
    function automatic logic [2:0] next_color(input logic [2:0] c);
        return (c == 3'd7) ? 3'd1 : c + 3'd1;
    endfunction

endpackage

// File: rtl/vga_bounce_renderer_bounce_axis.sv
// bounce_axis: position/direction state for one axis of the bouncing box.
// On each update strobe the position moves STEP pixels in the current
// direction; if the move would leave [0, LIMIT-SIZE] the position clamps to
// the edge, the direction flips and bounce pulses for that cycle.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   update      1-cycle strobe: apply one motion step
//   pos         current top/left coordinate of the box on this axis
//   bounce      high in the update cycle that hits an edge
module bounce_axis #(
    parameter int LIMIT = 640,
    parameter int SIZE  = 32,
    parameter int STEP  = 2,
    parameter int INIT  = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       update,
    output logic [9:0] pos,
    output logic       bounce
);

    // 11-bit arithmetic so pos + SIZE + STEP can never wrap.
    localparam logic [10:0] LIMIT_W = 11'(LIMIT);
    localparam logic [10:0] SIZE_W  = 11'(SIZE);
    localparam logic [10:0] STEP_W  = 11'(STEP);
    localparam logic [9:0]  MAX_POS = 10'(LIMIT - SIZE);

    logic        dir_pos;   // 1 = moving towards larger coordinates
    logic [10:0] pos_w;
    logic [9:0]  pos_nxt;
    logic        dir_nxt;
    logic        hit;

    always_comb begin
        pos_w   = {1'b0, pos};
        pos_nxt = pos;
        dir_nxt = dir_pos;
        hit     = 1'b0;
        if (dir_pos) begin
            if (pos_w + SIZE_W + STEP_W > LIMIT_W) begin
                pos_nxt = MAX_POS;
                dir_nxt = 1'b0;
                hit     = 1'b1;
            end else begin
                pos_nxt = 10'(pos_w + STEP_W);
            end
        end else begin
            if (pos_w < STEP_W) begin
                pos_nxt = 10'd0;
                dir_nxt = 1'b1;
                hit     = 1'b1;
            end else begin
                pos_nxt = 10'(pos_w - STEP_W);
            end
        end
    end

    assign bounce = update & hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos     <= 10'(INIT);
            dir_pos <= 1'b1;
        end else if (update) begin
            pos     <= pos_nxt;
            dir_pos <= dir_nxt;
        end
    end

endmodule

// File: rtl/vga_bounce_renderer.sv
// vga_bounce_renderer: pixel stage behind the 640x480 VGA timing generator.
// Draws a solid bouncing square over a dark-blue background with a one-pixel
// white border. The box moves once per frame during vertical blanking via a
// small IDLE -> UPD_X -> UPD_Y FSM; every edge hit advances the box colour.
// The render path is two registers deep from hpos/vpos; the incoming syncs
// (already one cycle late) get one register, so rgb and syncs line up.
// Ports:
//   clk, rst_n            pixel clock, asynchronous active-low reset
//   hpos, vpos            pixel counters from the timing generator
//   display_on            visible-region flag (combinational from hpos/vpos)
//   hsync_in, vsync_in    active-low syncs, one cycle behind hpos/vpos
//   pause                 1 = do not move the box at the next frame tick
//   r, g, b               2-bit colour channels
//   hsync_out, vsync_out  active-low syncs aligned to r/g/b
module vga_bounce_renderer
    import vga_pkg::*;
#(
    parameter int BOX_SIZE = 32,
    parameter int STEP     = 2,
    parameter int INIT_X   = 100,
    parameter int INIT_Y   = 80
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] hpos,
    input  logic [9:0] vpos,
    input  logic       display_on,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       pause,
    output logic [1:0] r,
    output logic [1:0] g,
    output logic [1:0] b,
    output logic       hsync_out,
    output logic       vsync_out
);

    localparam logic [10:0] BOX_W = 11'(BOX_SIZE);

    // ------------------------------------------------------------------
    // Motion FSM
    // ------------------------------------------------------------------
    motion_state_t state;
    motion_state_t state_nxt;
    logic          frame_tick;
    logic          upd_x;
    logic          upd_y;
    logic [9:0]    box_x;
    logic [9:0]    box_y;
    logic          bounce_x;
    logic          bounce_y;
    logic [2:0]    color_idx;

    // First pixel of the first blanking line: exactly one per frame.
    assign frame_tick = (vpos == 10'(V_VISIBLE)) && (hpos == 10'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        upd_x     = 1'b0;
        upd_y     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (frame_tick && !pause) begin
                    state_nxt = ST_UPD_X;
                end
            end
            ST_UPD_X: begin
                upd_x     = 1'b1;
                state_nxt = ST_UPD_Y;
            end
            ST_UPD_Y: begin
                upd_y     = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    bounce_axis #(
        .LIMIT (H_VISIBLE),
        .SIZE  (BOX_SIZE),
        .STEP  (STEP),
        .INIT  (INIT_X)
    ) u_axis_x (
        .clk    (clk),
        .rst_n  (rst_n),
        .update (upd_x),
        .pos    (box_x),
        .bounce (bounce_x)
    );

    bounce_axis #(
        .LIMIT (V_VISIBLE),
        .SIZE  (BOX_SIZE),
        .STEP  (STEP),
        .INIT  (INIT_Y)
    ) u_axis_y (
        .clk    (clk),
        .rst_n  (rst_n),
        .update (upd_y),
        .pos    (box_y),
        .bounce (bounce_y)
    );

    // X and Y update in different cycles, so a corner hit advances the
    // colour twice without the two bounces ever colliding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            color_idx <= 3'd1;
        end else if (bounce_x || bounce_y) begin
            color_idx <= next_color(color_idx);
        end
    end

    // ------------------------------------------------------------------
    // Render pipeline
    // ------------------------------------------------------------------
    logic       vis1;
    logic       box1;
    logic       edge1;
    logic       in_box;
    logic       on_edge;
    logic [10:0] h_w;
    logic [10:0] v_w;
    rgb_t       pix_nxt;
    rgb_t       pix2;

    always_comb begin
        h_w     = {1'b0, hpos};
        v_w     = {1'b0, vpos};
        in_box  = (h_w >= {1'b0, box_x}) && (h_w < {1'b0, box_x} + BOX_W) &&
                  (v_w >= {1'b0, box_y}) && (v_w < {1'b0, box_y} + BOX_W);
        on_edge = (hpos == 10'd0) || (hpos == 10'(H_VISIBLE - 1)) ||
                  (vpos == 10'd0) || (vpos == 10'(V_VISIBLE - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vis1  <= 1'b0;
            box1  <= 1'b0;
            edge1 <= 1'b0;
        end else begin
            vis1  <= display_on;
            box1  <= in_box;
            edge1 <= on_edge;
        end
    end

    // Blanking forces black; the box is drawn over the border.
    always_comb begin
        pix_nxt = '{r: C_BLACK, g: C_BLACK, b: C_BLACK};
        if (!vis1) begin
            pix_nxt = '{r: C_BLACK, g: C_BLACK, b: C_BLACK};
        end else if (box1) begin
            pix_nxt = palette(color_idx);
        end else if (edge1) begin
            pix_nxt = '{r: C_WHITE, g: C_WHITE, b: C_WHITE};
        end else begin
            pix_nxt = '{r: C_BLACK, g: C_BLACK, b: C_BG_B};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix2      <= '{r: C_BLACK, g: C_BLACK, b: C_BLACK};
            hsync_out <= 1'b1;
            vsync_out <= 1'b1;
        end else begin
            pix2      <= pix_nxt;
            hsync_out <= hsync_in;
            vsync_out <= vsync_in;
        end
    end

    assign r = pix2.r;
    assign g = pix2.g;
    assign b = pix2.b;

endmodule

// File: tb/tb_vga_bounce_renderer.sv
// Bench for vga_bounce_renderer: directed pixel probes whose expected
// {r,g,b,hsync,vsync} are queued at drive time and checked by a monitor
// two clocks later. Box positions are derived by hand from the bounce rules:
//   ticks n after reset: x = 100+2n up to 608 (n=254), first x bounce n=255,
//   then bounces every 305 ticks; y = 80+2n up to 448 (n=184), first y bounce
//   n=185, then every 225 ticks; both bounce at n=5135 (bottom-right corner).
module tb_vga_bounce_renderer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] hpos = 10'd700;
    logic [9:0] vpos = 10'd500;
    logic       display_on = 1'b0;
    logic       hsync_in = 1'b1;
    logic       vsync_in = 1'b1;
    logic       pause = 1'b0;
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
    logic       hsync_out;
    logic       vsync_out;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    vga_bounce_renderer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hpos       (hpos),
        .vpos       (vpos),
        .display_on (display_on),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .pause      (pause),
        .r          (r),
        .g          (g),
        .b          (b),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out)
    );

    localparam logic [5:0] BLACK = 6'b00_00_00;
    localparam logic [5:0] BG    = 6'b00_00_01;
    localparam logic [5:0] WHITE = 6'b11_11_11;
    localparam logic [5:0] C1    = 6'b00_00_11;
    localparam logic [5:0] C2    = 6'b00_11_00;
    localparam logic [5:0] C3    = 6'b00_11_11;
    localparam logic [5:0] C4    = 6'b11_00_00;
    localparam logic [5:0] C6    = 6'b11_11_00;
    localparam logic [5:0] C7    = 6'b11_11_11;

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    int         tag_q[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         probe_idx = 0;
    logic       vld_now = 1'b0;
    logic       vld_d1 = 1'b0;
    logic       vld_d2 = 1'b0;
    logic       prev_hs = 1'b1;
    logic       prev_vs = 1'b1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_d1 <= 1'b0;
            vld_d2 <= 1'b0;
        end else begin
            vld_d1 <= vld_now;
            vld_d2 <= vld_d1;
        end
    end

    always @(negedge clk) begin
        logic [7:0] e;
        int         t;
        if (rst_n && vld_d2) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: got %b, no expected entry",
                         {r, g, b, hsync_out, vsync_out});
            end else begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                if ({r, g, b, hsync_out, vsync_out} !== e) begin
                    n_fail++;
                    $display("FAIL probe h=%0d v=%0d: got rgbhv=%b required %b",
                             t / 1024, t % 1024, {r, g, b, hsync_out, vsync_out}, e);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Syncs trail hpos/vpos by one cycle, as they do from the timing generator.
    task automatic drive(input int h, input int v, input logic de,
                         input logic hs, input logic vs, input logic vld);
        @(posedge clk);
        #1;
        hpos       = 10'(h);
        vpos       = 10'(v);
        display_on = de;
        hsync_in   = prev_hs;
        vsync_in   = prev_vs;
        prev_hs    = hs;
        prev_vs    = vs;
        vld_now    = vld;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(700, 500, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic tick();
        drive(0, 480, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(3);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic probe_de(input int h, input int v, input logic de, input logic [5:0] rgb);
        logic hs;
        logic vs;
        hs = probe_idx[0];
        vs = probe_idx[1];
        probe_idx++;
        exp_q.push_back({rgb, hs, vs});
        tag_q.push_back(h * 1024 + v);
        drive(h, v, de, hs, vs, 1'b1);
        idle(1);
    endtask

    task automatic probe(input int h, input int v, input logic [5:0] rgb);
        probe_de(h, v, 1'b1, rgb);
    endtask

    task automatic check_reset_outputs(input string name);
        n_checks++;
        if ({r, g, b, hsync_out, vsync_out} !== 8'b000000_11) begin
            n_fail++;
            $display("FAIL %s: got rgbhv=%b required 00000011", name,
                     {r, g, b, hsync_out, vsync_out});
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("power_on_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // n=0: box at (100,80), colour 1
        probe(110, 90, C1);
        probe(5, 5, BG);
        probe(0, 5, WHITE);
        probe_de(110, 90, 1'b0, BLACK);
        probe(100, 80, C1);
        probe(99, 80, BG);
        probe(100, 79, BG);
        probe(131, 111, C1);
        probe(132, 111, BG);
        probe(131, 112, BG);

        // three ticks move the box to (106,86)
        ticks(3);
        probe(106, 86, C1);
        probe(105, 86, BG);

        // asynchronous reset in the middle of a visible line
        for (int i = 0; i < 4; i++) drive(300, 100, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset_midline");
        prev_hs = 1'b1;
        prev_vs = 1'b1;
        idle(2);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);
        probe(100, 80, C1);
        probe(99, 80, BG);

        // pause holds the box over four ticks, then it moves one step
        pause = 1'b1;
        ticks(4);
        probe(100, 80, C1);
        probe(99, 80, BG);
        probe(100, 79, BG);
        pause = 1'b0;
        tick();
        probe(102, 82, C1);
        probe(101, 82, BG);
        probe(102, 81, BG);

        // n=184: y reaches 448, box overlaps the bottom border
        ticks(183);
        probe(468, 448, C1);
        probe(467, 448, BG);
        probe(468, 447, BG);
        probe(499, 479, C1);
        probe(500, 479, WHITE);

        // n=185: y bounce, colour 1 -> 2
        tick();
        probe(470, 448, C2);
        probe(469, 448, BG);

        // n=186: y moving up
        tick();
        probe(472, 446, C2);
        probe(472, 445, BG);
        probe(503, 477, C2);
        probe(503, 478, BG);

        // n=253..256: x 606, 608, 608 (bounce, colour 3), 606
        ticks(67);
        probe(606, 312, C2);
        probe(605, 312, BG);
        tick();
        probe(608, 310, C2);
        probe(607, 310, BG);
        tick();
        probe(608, 308, C3);
        probe(607, 308, BG);
        probe(639, 339, C3);
        tick();
        probe(606, 306, C3);
        probe(637, 306, C3);
        probe(638, 306, BG);
        probe(639, 306, WHITE);

        // n=862: colour 7 after six bounces; n=866: wraps to 1
        ticks(606);
        probe(604, 4, C7);
        probe(603, 4, BG);
        ticks(4);
        probe(606, 12, C1);
        probe(605, 12, BG);
        probe(606, 11, BG);

        // n=5134: at the bottom-right corner, still heading into it
        ticks(4268);
        probe(608, 448, C4);
        probe(607, 448, BG);
        probe(608, 447, BG);

        // n=5135: both axes bounce, colour 4 -> 6
        tick();
        probe(608, 448, C6);

        // n=5136: moving up-left away from the corner
        tick();
        probe(606, 446, C6);
        probe(605, 446, BG);
        probe(606, 445, BG);
        probe(637, 477, C6);
        probe(638, 477, BG);

        idle(4);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected outputs never appeared, required 0",
                     exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
